axi_sram_slave: RTL and testbench

//  AXI-style single-beat slave wrapping an on-chip SRAM of 2**MEM_AW words.

---
 rtl/axi_sram_pkg.sv | 10 +
 rtl/sram_1r1w.sv | 37 +++
 rtl/axi_sram_slave.sv | 160 ++++++++++++++++
 tb/tb_axi_sram_slave.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI-style single-beat SRAM slave.
package axi_sram_pkg;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

endpackage

// File: rtl/sram_1r1w.sv
// One-read/one-write SRAM: synchronous write, combinational read, per-word valid bits.
module sram_1r1w #(
  parameter int unsigned MEM_AW = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MEM_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvld
);

  localparam int unsigned Words = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem [Words];
  logic [Words-1:0]  valid_q;

  // Array contents are deliberately not reset; valid bits mask stale data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[waddr] <= 1'b1;
    end
  end

  assign rdata = mem[raddr];
  assign rvld  = valid_q[raddr];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-style single-beat SRAM slave with independent write (AW/W/B) and read (AR/R) channels.
// Define AXI_SRAM_ADDR_CHECK_EN to reject addresses with bits set above MEM_AW+1.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 8
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              wr_en,
  input  logic              chip_en,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              bvalid,
  output logic              bresp,
  input  logic              bready
);

  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  logic              aw_have_q, w_have_q, aw_oor_q, bresp_q;
  logic [MEM_AW-1:0] aw_idx_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  logic aw_hs, w_hs, ar_hs, b_done, commit, write_ok;
  logic aw_oor_in, ar_oor_in, aw_oor;
  logic [MEM_AW-1:0] aw_idx, ar_idx;
  logic [DATA_W-1:0] wr_data, mem_rdata;
  logic mem_rvld;

`ifdef AXI_SRAM_ADDR_CHECK_EN
  assign aw_oor_in = |awaddr[ADDR_W-1:MEM_AW+2];
  assign ar_oor_in = |araddr[ADDR_W-1:MEM_AW+2];
`else
  assign aw_oor_in = 1'b0;
  assign ar_oor_in = 1'b0;
`endif

  // Upper and byte-offset address bits are not used by the default build.
  logic unused_addr;
  assign unused_addr = ^{awaddr, araddr};

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign ar_hs  = arvalid & arready;
  assign b_done = bvalid & bready;

  // A handshake in the current cycle counts as latched, so commit happens as soon as both exist.
  assign aw_idx   = aw_hs ? awaddr[MEM_AW+1:2] : aw_idx_q;
  assign aw_oor   = aw_hs ? aw_oor_in : aw_oor_q;
  assign wr_data  = w_hs ? wdata : wdata_q;
  assign commit   = (w_state_q == W_IDLE) & (aw_have_q | aw_hs) & (w_have_q | w_hs);
  assign write_ok = commit & ~wr_en & chip_en & ~aw_oor;
  assign ar_idx   = araddr[MEM_AW+1:2];

  sram_1r1w #(
    .MEM_AW (MEM_AW),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk   (aclk),
    .rst_n (areset_n),
    .we    (write_ok),
    .waddr (aw_idx),
    .wdata (wr_data),
    .raddr (ar_idx),
    .rdata (mem_rdata),
    .rvld  (mem_rvld)
  );

  // Write channel latches and response.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      aw_idx_q  <= '0;
      aw_oor_q  <= 1'b0;
      wdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_have_q <= 1'b1;
        aw_idx_q  <= awaddr[MEM_AW+1:2];
        aw_oor_q  <= aw_oor_in;
      end
      if (w_hs) begin
        w_have_q <= 1'b1;
        wdata_q  <= wdata;
      end
      if (commit) bresp_q <= write_ok ? RESP_OKAY : RESP_ERR;
      if (b_done) begin
        aw_have_q <= 1'b0;
        w_have_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) w_state_q <= W_IDLE;
    else           w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:  if (commit) w_state_d = W_RESP;
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state_q == W_IDLE) & ~aw_have_q;
    wready  = (w_state_q == W_IDLE) & ~w_have_q;
    bvalid  = (w_state_q == W_RESP);
    bresp   = bresp_q;
  end

  // Read channel: data is captured at AR handshake, so a same-cycle write is not visible.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rdata_q <= '0;
    end else if (ar_hs) begin
      rdata_q <= (chip_en & ~ar_oor_in & mem_rvld) ? mem_rdata : '0;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state_q <= R_IDLE;
    else           r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:  if (arvalid) r_state_d = R_DATA;
      R_DATA:  if (rready)  r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state_q == R_IDLE);
    rvalid  = (r_state_q == R_DATA);
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default build, no address check).
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        wr_en, chip_en;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, arvalid, arready;
  logic        rvalid, rready, bvalid, bresp, bready;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  axi_sram_slave #(
    .ADDR_W (32),
    .DATA_W (32),
    .MEM_AW (8)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .wr_en    (wr_en),
    .chip_en  (chip_en),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .bvalid   (bvalid),
    .bresp    (bresp),
    .bready   (bready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic aw_send(input logic [31:0] a);
    awaddr = a; awvalid = 1'b1; tick(); awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d);
    wdata = d; wvalid = 1'b1; tick(); wvalid = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic exp_resp);
    check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    check({tag, "_bresp"}, {31'd0, bresp}, {31'd0, exp_resp});
    bready = 1'b1; tick(); bready = 1'b0;
    check({tag, "_bvalid_clr"}, {31'd0, bvalid}, 32'd0);
    check({tag, "_ready_back"}, {30'd0, awready, wready}, 32'd3);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    araddr = a; arvalid = 1'b1; tick(); arvalid = 1'b0;
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_arready_lo"}, {31'd0, arready}, 32'd0);
    check({tag, "_rdata"}, rdata, exp);
    rready = 1'b1; tick(); rready = 1'b0;
    check({tag, "_rvalid_clr"}, {31'd0, rvalid}, 32'd0);
    check({tag, "_arready_hi"}, {31'd0, arready}, 32'd1);
  endtask

  initial begin
    areset_n = 1'b0; wr_en = 1'b1; chip_en = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; bready = 1'b0;
    tick(); tick();
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    check("rst_valids", {29'd0, bvalid, rvalid, bresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    areset_n = 1'b1;
    tick();

    // T1: writes disabled -> error response, location stays unwritten.
    wr_en = 1'b1;
    aw_send(32'hDEADBEEF);
    check("t1_aw_lat", {30'd0, awready, wready}, 32'd1);
    check("t1_no_b", {31'd0, bvalid}, 32'd0);
    w_send(32'h0000_1234);
    b_take("t1", 1'b1);
    read_chk("t1_rd", 32'hDEADBEEF, 32'd0);

    // T2: writes enabled, read held until rready.
    wr_en = 1'b0;
    aw_send(32'hFADECAFE);
    w_send(32'h0000_1234);
    b_take("t2", 1'b0);
    araddr = 32'hFADECAFE; arvalid = 1'b1; tick(); arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_rvalid", {31'd0, rvalid}, 32'd1);
      check("t2_hold_rdata", rdata, 32'h0000_1234);
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    check("t2_rvalid_clr", {31'd0, rvalid}, 32'd0);

    // T3: AW and W together; response exactly one edge later.
    awaddr = 32'h10; awvalid = 1'b1; wdata = 32'hA5A5A5A5; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    b_take("t3", 1'b0);
    read_chk("t3_rd", 32'h10, 32'hA5A5A5A5);

    // T4: W before AW, stalled response; extra valids must be ignored.
    w_send(32'h5A5A0001);
    check("t4_w_first", {29'd0, awready, wready, bvalid}, 32'd4);
    aw_send(32'h14);
    awaddr = 32'h18; awvalid = 1'b1; wdata = 32'hBAD0BAD0; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_stall", {28'd0, bvalid, bresp, awready, wready}, 32'h8);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0;
    b_take("t4", 1'b0);
    read_chk("t4_rd", 32'h14, 32'h5A5A0001);
    read_chk("t4_rd_ign", 32'h18, 32'd0);

    // T5: chip disabled rejects the write; disabled read returns zero.
    chip_en = 1'b0;
    aw_send(32'h20);
    w_send(32'h0000_0077);
    b_take("t5", 1'b1);
    read_chk("t5_rd_ce0", 32'h10, 32'd0);
    chip_en = 1'b1;
    read_chk("t5_rd", 32'h20, 32'd0);

    // Same-cycle commit and read to one index returns the old word.
    awaddr = 32'h10; awvalid = 1'b1; wdata = 32'hCAFE0000; wvalid = 1'b1;
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("rw_rdata_old", rdata, 32'hA5A5A5A5);
    check("rw_valids", {30'd0, bvalid, rvalid}, 32'd3);
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
    read_chk("rw_new", 32'h10, 32'hCAFE0000);
    read_chk("alias", 32'h0000_0410, 32'hCAFE0000);

    // T6: reset while a response is pending clears outputs immediately.
    wr_en = 1'b1;
    aw_send(32'h30);
    w_send(32'h0000_1111);
    check("t6_pre", {30'd0, bvalid, bresp}, 32'd3);
    areset_n = 1'b0;
    #1;
    check("t6_readies", {29'd0, awready, wready, arready}, 32'd7);
    check("t6_valids", {29'd0, bvalid, rvalid, bresp}, 32'd0);
    check("t6_rdata", rdata, 32'd0);
    tick();
    areset_n = 1'b1;
    tick();
    wr_en = 1'b0;
    aw_send(32'h40);
    areset_n = 1'b0; tick(); areset_n = 1'b1; tick();
    w_send(32'h0000_2222);
    check("t6_no_commit", {31'd0, bvalid}, 32'd0);
    read_chk("t6_rd_cleared", 32'h10, 32'd0);
    read_chk("t6_rd_aborted", 32'h40, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
